// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the core memory responder: port FSM states,
// jitter LFSR constants and the byte-address to word-index mapping.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_port_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Drops the two byte-offset bits and wraps modulo the RAM depth.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned mem_words);
    return (addr >> 2) & (mem_words - 1);
  endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One request port of the memory responder: accept/wait/respond FSM, latency
// counter and request latch; raises access on the edge that enters RESP.
module mem_port_fsm
  import core_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic                       we,
  input  logic [BYTE_DATA_WIDTH-1:0] be,
  input  logic [DATA_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [1:0]                 extra,
  output logic                       access,
  output logic                       acc_we,
  output logic [BYTE_DATA_WIDTH-1:0] acc_be,
  output logic [DATA_WIDTH-1:0]      acc_addr,
  output logic [DATA_WIDTH-1:0]      acc_wdata,
  output logic                       valid,
  output mem_port_state_t            state
);

  mem_port_state_t             state_q, state_d;
  logic [4:0]                  cnt_q, cnt_d;
  logic [4:0]                  load;
  logic                        we_q, we_d;
  logic [BYTE_DATA_WIDTH-1:0]  be_q, be_d;
  logic [DATA_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load    = 5'(LATENCY - 1) + {3'b000, extra};
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          be_d    = be;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = load;
          state_d = (load == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 5'd1) begin
          cnt_d   = 5'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RESP);
  end

  // A zero-wait accept goes straight to RESP, so the live inputs are used on that edge.
  always_comb begin
    access    = (state_d == RESP) && (state_q != RESP) && !rst;
    acc_we    = (state_q == IDLE) ? we    : we_q;
    acc_be    = (state_q == IDLE) ? be    : be_q;
    acc_addr  = (state_q == IDLE) ? addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign state = state_q;

endmodule

// File: rtl/core_mem_responder.sv
// Unified word RAM answering the core's inst and data ports with fixed latency.
// Define MEM_RESP_JITTER_EN to add 0..3 LFSR-driven extra wait cycles per accept.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_req,
  input  logic [DATA_WIDTH-1:0]      inst_addr,
  output logic                       inst_valid,
  output logic [DATA_WIDTH-1:0]      inst_data,
  input  logic                       data_req,
  output logic                       data_valid,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  output logic [DATA_WIDTH-1:0]      rdata,
  input  logic [DATA_WIDTH-1:0]      wdata
);

  localparam int IW = $clog2(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic                       i_access, i_acc_we, d_access, d_acc_we;
  logic [BYTE_DATA_WIDTH-1:0] i_acc_be, d_acc_be;
  logic [DATA_WIDTH-1:0]      i_acc_addr, i_acc_wdata, d_acc_addr, d_acc_wdata;
  logic [1:0]                 i_extra, d_extra;
  logic [31:0]                i_word, d_word;
  mem_port_state_t            inst_state, data_state;
  logic [DATA_WIDTH-1:0]      inst_data_q, inst_data_d, rdata_q, rdata_d;
  logic                       lint_unused;

`ifdef MEM_RESP_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign i_extra = lfsr_q[1:0];
  assign d_extra = lfsr_q[3:2];
`else
  assign i_extra = 2'b00;
  assign d_extra = 2'b00;
`endif

  mem_port_fsm #(
    .DATA_WIDTH(DATA_WIDTH), .BYTE_DATA_WIDTH(BYTE_DATA_WIDTH), .LATENCY(LATENCY)
  ) u_inst_port (
    .clk(clk), .rst(rst), .req(inst_req), .we(1'b0), .be('0), .addr(inst_addr),
    .wdata('0), .extra(i_extra), .access(i_access), .acc_we(i_acc_we),
    .acc_be(i_acc_be), .acc_addr(i_acc_addr), .acc_wdata(i_acc_wdata),
    .valid(inst_valid), .state(inst_state)
  );

  mem_port_fsm #(
    .DATA_WIDTH(DATA_WIDTH), .BYTE_DATA_WIDTH(BYTE_DATA_WIDTH), .LATENCY(LATENCY)
  ) u_data_port (
    .clk(clk), .rst(rst), .req(data_req), .we(data_we), .be(byte_enable),
    .addr(data_addr), .wdata(wdata), .extra(d_extra), .access(d_access),
    .acc_we(d_acc_we), .acc_be(d_acc_be), .acc_addr(d_acc_addr),
    .acc_wdata(d_acc_wdata), .valid(data_valid), .state(data_state)
  );

  assign i_word = word_index(32'(i_acc_addr), MEM_WORDS);
  assign d_word = word_index(32'(d_acc_addr), MEM_WORDS);

  // Reads sample the pre-edge contents, so a same-edge inst read sees the old word.
  always_comb begin
    inst_data_d = inst_data_q;
    rdata_d     = rdata_q;
    if (i_access) inst_data_d = mem_q[i_word[IW-1:0]];
    if (d_access && !d_acc_we) rdata_d = mem_q[d_word[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (d_access && d_acc_we) begin
      for (int b = 0; b < BYTE_DATA_WIDTH; b++) begin
        if (d_acc_be[b]) mem_q[d_word[IW-1:0]][8*b +: 8] <= d_acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_data_q <= '0;
      rdata_q     <= '0;
    end else begin
      inst_data_q <= inst_data_d;
      rdata_q     <= rdata_d;
    end
  end

  assign inst_data = inst_data_q;
  assign rdata     = rdata_q;

  assign lint_unused = ^{i_acc_we, i_acc_be, i_acc_wdata, inst_state, data_state,
                         i_word[31:IW], d_word[31:IW]};

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: directed scenarios plus a randomized run
// against a word-array reference model; honours MEM_RESP_JITTER_EN.
module tb_core_mem_responder;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MW = 1024;
  localparam int L  = 2;
`ifdef MEM_RESP_JITTER_EN
  localparam int JMAX = 3;
  localparam int NRAND = 1000;
`else
  localparam int JMAX = 0;
  localparam int NRAND = 300;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req, data_we;
  logic [DW-1:0] inst_addr, data_addr, wdata;
  logic [BW-1:0] byte_enable;
  logic          inst_valid, data_valid;
  logic [DW-1:0] inst_data, rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] ref_mem [MW];
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] exp_q [$];

  core_mem_responder #(
    .DATA_WIDTH(DW), .BYTE_DATA_WIDTH(BW), .MEM_WORDS(MW), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst_data(inst_data), .data_req(data_req),
    .data_valid(data_valid), .data_we(data_we), .byte_enable(byte_enable),
    .data_addr(data_addr), .rdata(rdata), .wdata(wdata)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [DW-1:0] a);
    return int'((a / 4) % MW);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic bit lat_bad(input int lat);
    return (lat < L) || (lat > L + JMAX);
  endfunction

  // Driver: call #1 after a posedge. Lat is counted in edges from the drive point,
  // so the accept edge is 1 and a valid seen after edge L means latency L.
  // Each req stays high through its RESP cycle and drops after the edge ending it.
  task automatic do_pair(input bit di, input logic [DW-1:0] ia,
                         input bit dd, input bit we, input logic [BW-1:0] be,
                         input logic [DW-1:0] da, input logic [DW-1:0] wd,
                         output logic [DW-1:0] idat, output logic [DW-1:0] ddat,
                         output int ilat, output int dlat,
                         output int icyc, output bit spur);
    bit i_drop, d_drop;
    int n;
    inst_req = di; inst_addr = ia;
    data_req = dd; data_we = we; byte_enable = be; data_addr = da; wdata = wd;
    idat = 'x; ddat = 'x; ilat = -1; dlat = -1; icyc = -1; spur = 0;
    i_drop = !di; d_drop = !dd; n = 0;
    while (!(i_drop && d_drop) && n < 40) begin
      @(posedge clk); #1; n++;
      if (inst_valid) begin
        if (!di || ilat >= 0) spur = 1;
        else begin ilat = n; icyc = cyc; idat = inst_data; end
      end
      if (data_valid) begin
        if (!dd || dlat >= 0) spur = 1;
        else begin dlat = n; ddat = rdata; end
      end
      if (!i_drop && ilat >= 0 && n == ilat + 1) begin inst_req = 0; i_drop = 1; end
      if (!d_drop && dlat >= 0 && n == dlat + 1) begin data_req = 0; d_drop = 1; end
    end
    inst_req = 0; data_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; inst_req = 0; data_req = 0; data_we = 0; byte_enable = '0;
    inst_addr = '0; data_addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({inst_valid, data_valid, inst_data, rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got iv=%b dv=%b idata=%h rdata=%h required all zero",
               inst_valid, data_valid, inst_data, rdata);
    end
    rst = 0;
    exp_rdata = '0;
    idle(4);
    tests++;
    if (inst_valid !== 1'b0 || data_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_valid: got iv=%b dv=%b required 0 0", inst_valid, data_valid);
    end
  endtask

  task automatic test_inst_fetch();
    logic [DW-1:0] id, dd;
    int il, dl, ic;
    bit sp;
    do_pair(0, '0, 1, 1, 4'hF, 32'h40, 32'hDEADBEEF, id, dd, il, dl, ic, sp);
    ref_mem[widx(32'h40)] = 32'hDEADBEEF;
    tests++;
    if (lat_bad(dl) || sp) begin
      fails++;
      $display("FAIL preload_store: got lat=%0d spur=%b required lat %0d..%0d", dl, sp, L, L + JMAX);
    end
    idle(1);
    do_pair(1, 32'h40, 0, 0, '0, '0, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (lat_bad(il) || sp) begin
      fails++;
      $display("FAIL fetch_latency: got lat=%0d spur=%b required lat %0d..%0d", il, sp, L, L + JMAX);
    end
    tests++;
    if (id !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL fetch_data: got %h required deadbeef", id);
    end
  endtask

  task automatic test_byte_store();
    logic [DW-1:0] id, dd;
    int il, dl, ic;
    bit sp;
    do_pair(0, '0, 1, 1, 4'hF, 32'h80, 32'hAABBCCDD, id, dd, il, dl, ic, sp);
    do_pair(0, '0, 1, 1, 4'b0101, 32'h80, 32'h11223344, id, dd, il, dl, ic, sp);
    tests++;
    if (lat_bad(dl) || sp || dd !== exp_rdata) begin
      fails++;
      $display("FAIL store_pulse: got lat=%0d spur=%b rdata=%h required one pulse, rdata held %h",
               dl, sp, dd, exp_rdata);
    end
    do_pair(0, '0, 1, 0, '0, 32'h80, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (dd !== 32'hAA22CC44 || lat_bad(dl)) begin
      fails++;
      $display("FAIL byte_lane_load: got %h lat=%0d required aa22cc44", dd, dl);
    end
    exp_rdata = 32'hAA22CC44;
    do_pair(0, '0, 1, 1, 4'b0000, 32'h80, 32'h55555555, id, dd, il, dl, ic, sp);
    tests++;
    if (lat_bad(dl) || sp) begin
      fails++;
      $display("FAIL empty_store_pulse: got lat=%0d spur=%b required valid pulse", dl, sp);
    end
    do_pair(0, '0, 1, 0, '0, 32'h80, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (dd !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL empty_store_noop: got %h required aa22cc44", dd);
    end
    ref_mem[widx(32'h80)] = 32'hAA22CC44;
  endtask

  task automatic test_same_edge();
    logic [DW-1:0] id, dd, exp_i;
    int il, dl, ic;
    bit sp;
    do_pair(0, '0, 1, 1, 4'hF, 32'h100, 32'h0, id, dd, il, dl, ic, sp);
    do_pair(1, 32'h100, 1, 1, 4'hF, 32'h100, 32'hCAFEF00D, id, dd, il, dl, ic, sp);
    // Reads taken on the write edge or earlier see the old word.
    exp_i = (dl < il) ? 32'hCAFEF00D : 32'h0;
    tests++;
    if (id !== exp_i || lat_bad(il) || lat_bad(dl) || sp) begin
      fails++;
      $display("FAIL same_edge_rbw: got %h il=%0d dl=%0d required %h", id, il, dl, exp_i);
    end
    do_pair(1, 32'h100, 0, 0, '0, '0, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (id !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL same_edge_after: got %h required cafef00d", id);
    end
    ref_mem[widx(32'h100)] = 32'hCAFEF00D;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] id, dd;
    int il, dl, c1, c2;
    bit sp1, sp2, extra;
    do_pair(1, 32'h40, 0, 0, '0, '0, '0, id, dd, il, dl, c1, sp1);
    do_pair(1, 32'h40, 0, 0, '0, '0, '0, id, dd, il, dl, c2, sp2);
    tests++;
    if ((c2 - c1) < L + 1 || (c2 - c1) > L + 1 + JMAX || sp1 || sp2) begin
      fails++;
      $display("FAIL back_to_back_gap: got %0d cycles spur=%b%b required %0d..%0d",
               c2 - c1, sp1, sp2, L + 1, L + 1 + JMAX);
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (inst_valid) extra = 1;
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL no_reaccept: got extra inst_valid required none");
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] id, dd;
    int il, dl, ic;
    bit sp, seen;
    data_req = 1; data_we = 1; byte_enable = 4'hF; data_addr = 32'h80; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    tests++;
    if ({inst_valid, data_valid, inst_data, rdata} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got iv=%b dv=%b idata=%h rdata=%h required all zero",
               inst_valid, data_valid, inst_data, rdata);
    end
    rst = 0; data_req = 0;
    exp_rdata = '0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (data_valid) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_no_valid: got data_valid required none");
    end
    do_pair(0, '0, 1, 0, '0, 32'h80, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (dd !== 32'hAA22CC44) begin
      fails++;
      $display("FAIL abort_no_write: got %h required aa22cc44", dd);
    end
    exp_rdata = 32'hAA22CC44;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] id, dd;
    int il, dl, ic;
    bit sp;
    do_pair(0, '0, 1, 0, '0, 32'h40 + MW * 4, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (dd !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL addr_wrap: got %h required deadbeef", dd);
    end
    do_pair(1, 32'h43, 1, 0, '0, 32'h43, '0, id, dd, il, dl, ic, sp);
    tests++;
    if (dd !== 32'hDEADBEEF || id !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL low_bits_ignored: got rdata=%h idata=%h required deadbeef", dd, id);
    end
    exp_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_random();
    logic [DW-1:0] id, dd, ia, da, wd, old_i, old_d, got;
    logic [BW-1:0] be;
    int il, dl, ic, kind;
    bit sp, we, di, dq;
    for (int k = 0; k < 16; k++) begin
      wd = $urandom;
      do_pair(0, '0, 1, 1, 4'hF, 32'h200 + 4 * k, wd, id, dd, il, dl, ic, sp);
      ref_mem[widx(32'h200 + 4 * k)] = wd;
    end
    for (int t = 0; t < NRAND; t++) begin
      kind = $urandom_range(0, 2);
      di = (kind != 1);
      dq = (kind != 0);
      ia = $urandom_range(0, 7) * MW * 4 + 32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      da = $urandom_range(0, 7) * MW * 4 + 32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      we = $urandom_range(0, 1);
      be = $urandom_range(0, 15);
      wd = $urandom;
      old_i = ref_mem[widx(ia)];
      old_d = ref_mem[widx(da)];
      do_pair(di, ia, dq, we, be, da, wd, id, dd, il, dl, ic, sp);
      tests++;
      if (sp || (di && lat_bad(il)) || (dq && lat_bad(dl))) begin
        fails++;
        $display("FAIL rand_timing[%0d]: got il=%0d dl=%0d spur=%b", t, il, dl, sp);
      end
      if (di) begin
        if (dq && we && widx(ia) == widx(da) && dl < il) exp_q.push_back(merge(old_d, wd, be));
        else exp_q.push_back(old_i);
      end
      if (dq) begin
        if (we) ref_mem[widx(da)] = merge(old_d, wd, be);
        else exp_rdata = old_d;
        exp_q.push_back(exp_rdata);
      end
      if (di) begin
        got = exp_q.pop_front();
        tests++;
        if (id !== got) begin
          fails++;
          $display("FAIL rand_inst[%0d]: got %h required %h addr %h", t, id, got, ia);
        end
      end
      if (dq) begin
        got = exp_q.pop_front();
        tests++;
        if (dd !== got) begin
          fails++;
          $display("FAIL rand_data[%0d]: got %h required %h addr %h we %b", t, dd, got, da, we);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_inst_fetch();
    test_byte_store();
    test_same_edge();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
